ema_channel_scheduler: RTL

EMA_CHANNEL_SCHEDULER -- requirements
Module: ema_channel_scheduler

---
 rtl/ema_channel_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ema_channel_scheduler.sv
// ema_channel_scheduler
//   Time-shares one EMA datapath, y = x/4 + p/4 + p/2, across NCH input
//   streams. Channels are granted round-robin, one sample at a time, through
//   IDLE -> CALC -> OUT. Each channel keeps its own filter state p[k].
//
// Ports
//   ACLK, ARESETN            clock, async active-low reset
//   s_axis_tdata [NCH*DW]    channel k sample in bits [k*DW +: DW]
//   s_axis_tvalid/tready     per-channel handshake (at most one ready high)
//   m_axis_tdata/tdest       filtered sample and its channel index
//   m_axis_tvalid/tready     output handshake
//   chan_en                  per-channel grant eligibility
//   state_clr                1-cycle pulse, reload p[k] to INIT_STATE

// One channel's filter state. A clear beats a same-cycle write.
module ema_state_reg #(
  parameter int              DW   = 32,
  parameter logic [DW-1:0]   INIT = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= INIT;
    else if (clr) q <= INIT;
    else if (wr)  q <= wd;
  end
endmodule

module ema_channel_scheduler #(
  parameter int            NCH        = 4,
  parameter int            DW         = 32,
  parameter logic [DW-1:0] INIT_STATE = 'h3E8,
  parameter int            TW         = $clog2(NCH)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  input  logic [NCH-1:0]    s_axis_tvalid,
  output logic [NCH-1:0]    s_axis_tready,
  output logic [DW-1:0]     m_axis_tdata,
  output logic [TW-1:0]     m_axis_tdest,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [NCH-1:0]    chan_en,
  input  logic [NCH-1:0]    state_clr
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                   state, state_nxt;
  logic [NCH-1:0]           req;
  logic [NCH-1:0][DW-1:0]   p;
  logic [TW-1:0]            gnt, g_r, last_grant, rr_sel;
  logic                     gnt_vld;
  int                       rr_idx;
  logic [DW-1:0]            x_r, y, y_r;
  logic [TW-1:0]            dest_r;
  logic                     vld_r;
  logic                     out_hs;

  assign req    = s_axis_tvalid & chan_en;
  assign out_hs = (state == OUT) && m_axis_tready;

  // Round-robin: first requester strictly after last_grant, wrapping mod NCH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    rr_idx  = 0;
    rr_sel  = '0;
    for (int i = 1; i <= NCH; i++) begin
      rr_idx = (int'(last_grant) + i) % NCH;
      rr_sel = TW'(rr_idx);
      if (!gnt_vld && req[rr_sel]) begin
        gnt_vld = 1'b1;
        gnt     = rr_sel;
      end
    end
  end

  // Ready is combinational in IDLE; gated by reset so it drops immediately.
  always_comb begin
    s_axis_tready = '0;
    if (ARESETN && state == IDLE && gnt_vld) s_axis_tready[gnt] = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     if (m_axis_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifts drop fractional bits, so the sum never exceeds 2^DW-1.
  assign y = (x_r >> 2) + (p[g_r] >> 2) + (p[g_r] >> 1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      x_r        <= '0;
      g_r        <= '0;
      y_r        <= '0;
      dest_r     <= '0;
      vld_r      <= 1'b0;
      last_grant <= TW'(NCH - 1);
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          x_r <= s_axis_tdata[gnt*DW +: DW];
          g_r <= gnt;
        end
        CALC: begin
          y_r    <= y;
          dest_r <= g_r;
          vld_r  <= 1'b1;
        end
        OUT: if (m_axis_tready) begin
          vld_r      <= 1'b0;
          last_grant <= g_r;
        end
        default: ;
      endcase
    end
  end

  // State commits only on the output handshake, from the issued beat, so
  // a clear during CALC/OUT never alters data already presented.
  for (genvar k = 0; k < NCH; k++) begin : g_st
    ema_state_reg #(.DW(DW), .INIT(INIT_STATE)) u_st (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .clr   (state_clr[k]),
      .wr    (out_hs && (g_r == TW'(k))),
      .wd    (y_r),
      .q     (p[k])
    );
  end

  assign m_axis_tdata  = y_r;
  assign m_axis_tdest  = dest_r;
  assign m_axis_tvalid = vld_r;

endmodule
